// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired ALU control sequencer: state and opcode-class
// encodings, opcode/ALU-op constants, IR field positions and opcode decode helpers.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH0   = 4'd0,
        ST_FETCH1   = 4'd1,
        ST_FETCH2   = 4'd2,
        ST_EXEC3    = 4'd3,
        ST_EXEC4    = 4'd4,
        ST_EXEC5    = 4'd5,
        ST_EXEC6    = 4'd6,
        ST_BOUNDARY = 4'd7,
        ST_HALTED   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_BINARY  = 3'd0,
        CLS_MULDIV  = 3'd1,
        CLS_UNARY   = 3'd2,
        CLS_HALT    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } opclass_t;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_SHR  = 5'b00111;
    localparam logic [4:0] OPC_SHL  = 5'b01000;
    localparam logic [4:0] OPC_ROR  = 5'b01001;
    localparam logic [4:0] OPC_ROL  = 5'b01010;
    localparam logic [4:0] OPC_RSV0 = 5'b01011;
    localparam logic [4:0] OPC_RSV1 = 5'b01100;
    localparam logic [4:0] OPC_MUL  = 5'b01101;
    localparam logic [4:0] OPC_DIV  = 5'b01110;
    localparam logic [4:0] OPC_NEG  = 5'b01111;
    localparam logic [4:0] OPC_NOT  = 5'b10000;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD  = 5'b00100;
    localparam logic [4:0] ALU_SUB  = 5'b00101;
    localparam logic [4:0] ALU_AND  = 5'b00110;
    localparam logic [4:0] ALU_OR   = 5'b00111;
    localparam logic [4:0] ALU_SHR  = 5'b01000;
    localparam logic [4:0] ALU_SHL  = 5'b01001;
    localparam logic [4:0] ALU_ROR  = 5'b01010;
    localparam logic [4:0] ALU_ROL  = 5'b01011;
    localparam logic [4:0] ALU_RSV0 = 5'b01100;
    localparam logic [4:0] ALU_RSV1 = 5'b01101;
    localparam logic [4:0] ALU_MUL  = 5'b01110;
    localparam logic [4:0] ALU_DIV  = 5'b01111;
    localparam logic [4:0] ALU_NEG  = 5'b10000;
    localparam logic [4:0] ALU_NOT  = 5'b10001;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    function automatic opclass_t opcode_class(input logic [4:0] opcode);
        case (opcode)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
            OPC_SHL, OPC_ROR, OPC_ROL, OPC_RSV0, OPC_RSV1: return CLS_BINARY;
            OPC_MUL, OPC_DIV:                            return CLS_MULDIV;
            OPC_NEG, OPC_NOT:                            return CLS_UNARY;
            OPC_HALT:                                    return CLS_HALT;
            default:                                     return CLS_ILLEGAL;
        endcase
    endfunction

    // Each defined operation's ALU code is its opcode plus one.
    function automatic logic [4:0] alu_op(input logic [4:0] opcode);
        case (opcode)
            OPC_ADD:  return ALU_ADD;
            OPC_SUB:  return ALU_SUB;
            OPC_AND:  return ALU_AND;
            OPC_OR:   return ALU_OR;
            OPC_SHR:  return ALU_SHR;
            OPC_SHL:  return ALU_SHL;
            OPC_ROR:  return ALU_ROR;
            OPC_ROL:  return ALU_ROL;
            OPC_RSV0: return ALU_RSV0;
            OPC_RSV1: return ALU_RSV1;
            OPC_MUL:  return ALU_MUL;
            OPC_DIV:  return ALU_DIV;
            OPC_NEG:  return ALU_NEG;
            OPC_NOT:  return ALU_NOT;
            default:  return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register index to one-hot select decoder; all-zero output when not enabled.
module reg_select_decoder #(
    parameter int REGS = 16,
    parameter int IDXW = $clog2(REGS)
) (
    input  logic [IDXW-1:0] idx,
    input  logic            en,
    output logic [REGS-1:0] onehot
);

    // One-hot expansion of the selected register index.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired Moore control unit sequencing fetch and register-register ALU execution
// on the 32-bit bus datapath, with MUL/DIV two-half writeback, memory waits and halt.
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int REGS = 16
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic [31:0]     IR,
    input  logic            Mem_ready,
    input  logic            Stop,
    output logic [REGS-1:0] Rin,
    output logic [REGS-1:0] Rout,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Read,
    output logic            IRin,
    output logic            Yin,
    output logic            ZLowin,
    output logic            ZHighin,
    output logic            ZLowout,
    output logic            ZHighout,
    output logic            HIin,
    output logic            LOin,
    output logic [OPW-1:0]  OP,
    output logic            Run,
    output logic            Illegal
);

    state_t     state_r;
    state_t     next_s;
    logic       hold_r;
    opclass_t   class_s;
    logic [4:0] opcode_s;
    logic [3:0] ra_s;
    logic [3:0] rb_s;
    logic [3:0] rc_s;
    logic [3:0] rout_idx_s;
    logic       rin_en_s;
    logic       rout_en_s;
    logic       ir_unused_s;

    assign opcode_s    = IR[OPC_MSB:OPC_LSB];
    assign ra_s        = IR[RA_MSB:RA_LSB];
    assign rb_s        = IR[RB_MSB:RB_LSB];
    assign rc_s        = IR[RC_MSB:RC_LSB];
    assign ir_unused_s = ^IR[RC_LSB-1:0];
    assign class_s     = opcode_class(opcode_s);

    // Next-state sequencing; Mem_ready matters only in FETCH1, Stop only at BOUNDARY.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_FETCH0: next_s = ST_FETCH1;
            ST_FETCH1: begin
                if (Mem_ready) begin
                    next_s = ST_FETCH2;
                end else begin
                    next_s = ST_FETCH1;
                end
            end
            ST_FETCH2: next_s = ST_EXEC3;
            ST_EXEC3: begin
                case (class_s)
                    CLS_BINARY, CLS_MULDIV: next_s = ST_EXEC4;
                    CLS_UNARY:              next_s = ST_EXEC5;
                    CLS_HALT:               next_s = ST_HALTED;
                    default:                next_s = ST_FETCH0;
                endcase
            end
            ST_EXEC4: next_s = ST_EXEC5;
            ST_EXEC5: begin
                if (class_s == CLS_MULDIV) begin
                    next_s = ST_EXEC6;
                end else begin
                    next_s = ST_BOUNDARY;
                end
            end
            ST_EXEC6: next_s = ST_BOUNDARY;
            ST_BOUNDARY: begin
                if (Stop) begin
                    next_s = ST_HALTED;
                end else begin
                    next_s = ST_FETCH0;
                end
            end
            ST_HALTED: next_s = ST_HALTED;
            default:   next_s = ST_FETCH0;
        endcase
    end

    // State register; hold_r keeps a silent FETCH0 through the cycle after Clear releases.
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_r <= ST_FETCH0;
            hold_r  <= 1'b1;
        end else if (hold_r) begin
            state_r <= ST_FETCH0;
            hold_r  <= 1'b0;
        end else begin
            state_r <= next_s;
            hold_r  <= 1'b0;
        end
    end

    // Moore strobe decode from state and IR; PCin also qualifies on Mem_ready so PC loads once.
    always_comb begin
        PCout      = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        Read       = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        ZLowin     = 1'b0;
        ZHighin    = 1'b0;
        ZLowout    = 1'b0;
        ZHighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        OP         = '0;
        Illegal    = 1'b0;
        Run        = (state_r != ST_HALTED);
        rin_en_s   = 1'b0;
        rout_en_s  = 1'b0;
        rout_idx_s = rb_s;
        if (hold_r) begin
            Run = 1'b1;
        end else begin
            case (state_r)
                ST_FETCH0: begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                end
                ST_FETCH1: begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                    PCin  = Mem_ready;
                end
                ST_FETCH2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                ST_EXEC3: begin
                    case (class_s)
                        CLS_BINARY, CLS_MULDIV: begin
                            rout_en_s = 1'b1;
                            Yin       = 1'b1;
                        end
                        CLS_UNARY: begin
                            rout_en_s = 1'b1;
                            OP        = OPW'(alu_op(opcode_s));
                            ZLowin    = 1'b1;
                        end
                        CLS_ILLEGAL: Illegal = 1'b1;
                        default:     Illegal = 1'b0;
                    endcase
                end
                ST_EXEC4: begin
                    rout_en_s  = 1'b1;
                    rout_idx_s = rc_s;
                    OP         = OPW'(alu_op(opcode_s));
                    ZLowin     = 1'b1;
                    ZHighin    = (class_s == CLS_MULDIV);
                end
                ST_EXEC5: begin
                    ZLowout = 1'b1;
                    if (class_s == CLS_MULDIV) begin
                        LOin = 1'b1;
                    end else begin
                        rin_en_s = 1'b1;
                    end
                end
                ST_EXEC6: begin
                    ZHighout = 1'b1;
                    HIin     = 1'b1;
                end
                default: Illegal = 1'b0;
            endcase
        end
    end

    reg_select_decoder #(.REGS(REGS)) u_rin_dec (
        .idx    (ra_s),
        .en     (rin_en_s),
        .onehot (Rin)
    );

    reg_select_decoder #(.REGS(REGS)) u_rout_dec (
        .idx    (rout_idx_s),
        .en     (rout_en_s),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Randomized self-checking bench: an instruction-level model lists the expected strobe
// pattern of every cycle, which is compared against the sequencer's outputs.
module tb_alu_control_sequencer;

    logic        Clock;
    logic        Clear;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        Stop;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin;
    logic [4:0]  OP;
    logic        Run, Illegal;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
        logic pcout, pcin, incpc, marin, mdrin, mdrout, read, irin;
        logic yin, zlowin, zhighin, zlowout, zhighout, hiin, loin;
        logic run, illegal;
    } obs_t;

    obs_t obs_s;
    obs_t exp_q[$];
    obs_t got_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_control_sequencer #(.OPW(5), .REGS(16)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
        .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
        .Yin(Yin), .ZLowin(ZLowin), .ZHighin(ZHighin), .ZLowout(ZLowout),
        .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin), .OP(OP), .Run(Run),
        .Illegal(Illegal)
    );

    assign obs_s = '{rin: Rin, rout: Rout, op: OP, pcout: PCout, pcin: PCin, incpc: IncPC,
                     marin: MARin, mdrin: MDRin, mdrout: MDRout, read: Read, irin: IRin,
                     yin: Yin, zlowin: ZLowin, zhighin: ZHighin, zlowout: ZLowout,
                     zhighout: ZHighout, hiin: HIin, loin: LOin, run: Run, illegal: Illegal};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic obs_t idle_o();
        obs_t o;
        o = '0;
        o.run = 1'b1;
        return o;
    endfunction

    // 0 binary, 1 mul/div, 2 unary, 3 halt, 4 illegal
    function automatic int op_class(input logic [4:0] opc);
        if (opc >= 5'd3 && opc <= 5'd12) return 0;
        else if (opc == 5'd13 || opc == 5'd14) return 1;
        else if (opc == 5'd15 || opc == 5'd16) return 2;
        else if (opc == 5'd27) return 3;
        else return 4;
    endfunction

    task automatic build_expected(input logic [31:0] ir, input int waits);
        obs_t o;
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        int cls;
        opc = ir[31:27];
        ra  = ir[26:23];
        rb  = ir[22:19];
        rc  = ir[18:15];
        cls = op_class(opc);
        exp_q.delete();
        o = idle_o(); o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; exp_q.push_back(o);
        for (int w = 0; w < waits; w++) begin
            o = idle_o(); o.read = 1'b1; o.mdrin = 1'b1; exp_q.push_back(o);
        end
        o = idle_o(); o.read = 1'b1; o.mdrin = 1'b1; o.pcin = 1'b1; exp_q.push_back(o);
        o = idle_o(); o.mdrout = 1'b1; o.irin = 1'b1; exp_q.push_back(o);
        if (cls == 0 || cls == 1) begin
            o = idle_o(); o.rout = 16'h0001 << rb; o.yin = 1'b1; exp_q.push_back(o);
            o = idle_o(); o.rout = 16'h0001 << rc; o.op = opc + 5'd1; o.zlowin = 1'b1;
            o.zhighin = (cls == 1); exp_q.push_back(o);
            o = idle_o(); o.zlowout = 1'b1;
            if (cls == 1) o.loin = 1'b1; else o.rin = 16'h0001 << ra;
            exp_q.push_back(o);
            if (cls == 1) begin
                o = idle_o(); o.zhighout = 1'b1; o.hiin = 1'b1; exp_q.push_back(o);
            end
            exp_q.push_back(idle_o());
        end else if (cls == 2) begin
            o = idle_o(); o.rout = 16'h0001 << rb; o.op = opc + 5'd1; o.zlowin = 1'b1;
            exp_q.push_back(o);
            o = idle_o(); o.zlowout = 1'b1; o.rin = 16'h0001 << ra; exp_q.push_back(o);
            exp_q.push_back(idle_o());
        end else if (cls == 3) begin
            exp_q.push_back(idle_o());
        end else begin
            o = idle_o(); o.illegal = 1'b1; exp_q.push_back(o);
        end
    endtask

    // Runs one instruction from FETCH0, capturing outputs each cycle into got_q.
    task automatic run_instr(input logic [31:0] ir, input int waits,
                             input int stop_from, input int clear_at);
        int   cls, bidx, n;
        logic stop_b;
        obs_t zero_o;
        zero_o = '0;
        build_expected(ir, waits);
        got_q.delete();
        cls    = op_class(ir[31:27]);
        n      = exp_q.size();
        bidx   = (cls <= 2) ? n - 1 : -1;
        stop_b = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i >= 1 && i <= waits) Mem_ready = 1'b0;
            else if (i == waits + 1) Mem_ready = 1'b1;
            else Mem_ready = 1'($urandom);
            IR = (i < waits + 3) ? $urandom : ir;
            if (stop_from >= 0) Stop = (i >= stop_from);
            else if (i == bidx) Stop = 1'b0;
            else Stop = 1'($urandom);
            if (i == bidx) stop_b = Stop;
            @(negedge Clock);
            got_q.push_back(obs_s);
            if (i == clear_at) begin
                Clear = 1'b0;
                @(posedge Clock); #1;
                @(negedge Clock);
                got_q.push_back(obs_s);
                while (exp_q.size() > i + 1) void'(exp_q.pop_back());
                exp_q.push_back(idle_o());
                Clear = 1'b1;
                @(posedge Clock); #1;
                return;
            end
            @(posedge Clock); #1;
        end
        if (cls == 3 || stop_b) begin
            repeat (4) begin
                Mem_ready = 1'($urandom);
                Stop      = 1'($urandom);
                IR        = $urandom;
                @(negedge Clock);
                got_q.push_back(obs_s);
                exp_q.push_back(zero_o);
                @(posedge Clock); #1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        Clear = 1'b0;
        repeat (n) begin
            @(posedge Clock); #1;
        end
        Clear = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_reset();
        Clear = 1'b0; Mem_ready = 1'b1; Stop = 1'b0; IR = 32'h20228000;
        for (int c = 0; c < 2; c++) begin
            @(posedge Clock); #1;
            @(negedge Clock);
            n_checks++;
            if (obs_s !== idle_o()) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h expected %h", c, obs_s, idle_o());
            end
        end
        Clear = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_sub();
        run_instr(32'h20228000, 0, -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sub cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mem_wait();
        run_instr({5'b00011, 4'd9, 4'd10, 4'd11, 15'd0}, 3, -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL mem_wait cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_muldiv();
        for (int k = 0; k < 2; k++) begin
            run_instr({(k == 0) ? 5'b01101 : 5'b01110, 4'd2, 4'd3, 4'd6, 15'h5a5a}, k, -1, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL muldiv%0d cycle %0d: got %h expected %h", k, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_unary();
        run_instr({5'b10000, 4'd7, 4'd1, 4'd0, 15'd0}, 0, -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL unary cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal_halt();
        run_instr({5'b11111, 27'h1234567}, 1, -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL illegal cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        run_instr({5'b11011, 27'h0abcdef}, 0, -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL halt cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        do_reset(1);
    endtask

    task automatic test_stop();
        run_instr({5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 4, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stop cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        do_reset(2);
    endtask

    task automatic test_clear_mid();
        for (int k = 0; k < 2; k++) begin
            run_instr({5'b00011, 4'd4, 4'd5, 4'd6, 15'd0}, 0, -1, (k == 0) ? 4 : -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL clear_mid%0d cycle %0d: got %h expected %h", k, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] opc;
        for (int t = 0; t < 40; t++) begin
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'd27) opc = 5'd3;
            run_instr({opc, 27'($urandom)}, $urandom_range(0, 3), -1, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b instr %0d op %b cycle %0d: got %h expected %h",
                             t, opc, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        Clear = 1'b1; Mem_ready = 1'b1; Stop = 1'b0; IR = 32'h0;
        test_reset();
        test_sub();
        test_mem_wait();
        test_muldiv();
        test_unary();
        test_illegal_halt();
        test_stop();
        test_clear_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
